// File: rtl/decode_sb_if.sv
// Fetch-to-decode handshake: instruction valid/ready with its PC and encoding.
interface decode_sb_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     inst_i;

    modport master (output valid_i, pc_i, inst_i, input ready_o);
    modport slave  (input valid_i, pc_i, inst_i, output ready_o);
endinterface

// File: rtl/decode_sb.sv
// Decode/issue stage: format decode, immediate generation, operand read with
// optional writeback bypass, and a destination scoreboard that stalls on RAW hazards.
module decode_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NWB    = 2,
    parameter int BYPASS = 1,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_sb_if.slave        fe,
    output logic [RW-1:0]     r0num_o,
    output logic [RW-1:0]     r1num_o,
    input  logic [XLEN-1:0]   r0data_i,
    input  logic [XLEN-1:0]   r1data_i,
    input  logic [NWB-1:0]    wb_valid_i,
    input  logic [NWB*RW-1:0] wb_rd_i,
    input  logic [NWB*XLEN-1:0] wb_data_i,
    input  logic              flush_i,
    output logic              valid_ro,
    input  logic              ready_i,
    output logic [XLEN-1:0]   pc_ro,
    output logic [31:0]       inst_ro,
    output logic [XLEN-1:0]   rs1data_ro,
    output logic [XLEN-1:0]   rs2data_ro,
    output logic [XLEN-1:0]   imm_ro,
    output logic [RW-1:0]     rd_ro,
    output logic              rdwe_ro,
    output logic [NREG-1:0]   busy_o,
    output logic [31:0]       stall_cnt_o
);
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [31:0]     inst_q, inst_d, stall_q, stall_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            rdwe_q, rdwe_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [31:0]     inst, imm32;
    logic [RW-1:0]   rs1, rs2, rd;
    logic            is_r, is_i, is_s, is_b, is_u, is_j;
    logic            use1, use2, rdwe, cov1, cov2, haz, cke, ready, issue;
    logic [XLEN-1:0] byp1, byp2;

    always_comb begin
        inst  = fe.inst_i;
        rs1   = inst[15 +: RW];
        rs2   = inst[20 +: RW];
        rd    = inst[7 +: RW];
        is_r  = (inst[6:0] == OP_OP);
        is_i  = (inst[6:0] == OP_OPIMM) || (inst[6:0] == OP_JALR) || (inst[6:0] == OP_LOAD);
        is_s  = (inst[6:0] == OP_STORE);
        is_b  = (inst[6:0] == OP_BRANCH);
        is_u  = (inst[6:0] == OP_LUI) || (inst[6:0] == OP_AUIPC);
        is_j  = (inst[6:0] == OP_JAL);
        use1  = is_r | is_i | is_s | is_b;
        use2  = is_r | is_s | is_b;
        rdwe  = (is_r | is_i | is_u | is_j) && (rd != '0);

        imm32 = 32'h0;
        if (is_i) imm32 = {{20{inst[31]}}, inst[31:20]};
        if (is_s) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        if (is_b) imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (is_u) imm32 = {inst[31:12], 12'h000};
        if (is_j) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

        // Walk ports high to low so the lowest-index match ends up selected.
        cov1 = 1'b0;
        cov2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        for (int k = NWB - 1; k >= 0; k--) begin
            if (wb_valid_i[k] && (wb_rd_i[k*RW +: RW] == rs1)) begin
                cov1 = 1'b1;
                byp1 = wb_data_i[k*XLEN +: XLEN];
            end
            if (wb_valid_i[k] && (wb_rd_i[k*RW +: RW] == rs2)) begin
                cov2 = 1'b1;
                byp2 = wb_data_i[k*XLEN +: XLEN];
            end
        end

        haz   = (use1 && (rs1 != '0) && busy_q[rs1] && (!BYPASS_EN || !cov1)) ||
                (use2 && (rs2 != '0) && busy_q[rs2] && (!BYPASS_EN || !cov2));
        cke   = !valid_q || ready_i;
        ready = cke && !haz && !flush_i;
        issue = fe.valid_i && ready;

        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        rdwe_d  = rdwe_q;
        stall_d = stall_q;
        busy_d  = busy_q;

        if (flush_i)  valid_d = 1'b0;
        else if (cke) valid_d = issue;

        if (issue) begin
            pc_d   = fe.pc_i;
            inst_d = inst;
            rs1_d  = (rs1 == '0) ? '0 : (BYPASS_EN && cov1) ? byp1 : r0data_i;
            rs2_d  = (rs2 == '0) ? '0 : (BYPASS_EN && cov2) ? byp2 : r1data_i;
            imm_d  = XLEN'($signed(imm32));
            rd_d   = rd;
            rdwe_d = rdwe;
        end

        if (fe.valid_i && cke && haz && !flush_i) stall_d = stall_q + 32'd1;

        for (int k = 0; k < NWB; k++)
            if (wb_valid_i[k]) busy_d[wb_rd_i[k*RW +: RW]] = 1'b0;
        // A flushed instruction never writes back, so its reservation is dropped here.
        if (flush_i && valid_q && rdwe_q) busy_d[rd_q] = 1'b0;
        if (issue && rdwe) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rdwe_q  <= 1'b0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rdwe_q  <= rdwe_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign fe.ready_o   = ready;
    assign r0num_o      = rs1;
    assign r1num_o      = rs2;
    assign valid_ro     = valid_q;
    assign pc_ro        = pc_q;
    assign inst_ro      = inst_q;
    assign rs1data_ro   = rs1_q;
    assign rs2data_ro   = rs2_q;
    assign imm_ro       = imm_q;
    assign rd_ro        = rd_q;
    assign rdwe_ro      = rdwe_q;
    assign busy_o       = busy_q;
    assign stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_decode_sb.sv
// Directed bench for decode_sb: a bypassing instance plus a non-bypassing one fed the same stimulus.
module tb_decode_sb;
    logic        clk, rst_n, flush_i, ready_i;
    logic [31:0] r0data, r1data;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;

    logic [4:0]  r0num, r1num, rd_ro, nb_r0num, nb_r1num, nb_rd_ro;
    logic        valid_ro, rdwe_ro, nb_valid_ro, nb_rdwe_ro;
    logic [31:0] pc_ro, inst_ro, rs1_ro, rs2_ro, imm_ro, busy, stall;
    logic [31:0] nb_pc_ro, nb_inst_ro, nb_rs1_ro, nb_rs2_ro, nb_imm_ro, nb_busy, nb_stall;

    int checks = 0;
    int errors = 0;

    decode_sb_if #(.XLEN(32)) fe ();
    decode_sb_if #(.XLEN(32)) fe_nb ();

    decode_sb #(.XLEN(32), .NREG(32), .NWB(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .fe(fe), .r0num_o(r0num), .r1num_o(r1num),
        .r0data_i(r0data), .r1data_i(r1data), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .flush_i(flush_i), .valid_ro(valid_ro), .ready_i(ready_i),
        .pc_ro(pc_ro), .inst_ro(inst_ro), .rs1data_ro(rs1_ro), .rs2data_ro(rs2_ro),
        .imm_ro(imm_ro), .rd_ro(rd_ro), .rdwe_ro(rdwe_ro), .busy_o(busy), .stall_cnt_o(stall)
    );

    decode_sb #(.XLEN(32), .NREG(32), .NWB(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .fe(fe_nb), .r0num_o(nb_r0num), .r1num_o(nb_r1num),
        .r0data_i(r0data), .r1data_i(r1data), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .flush_i(flush_i), .valid_ro(nb_valid_ro), .ready_i(ready_i),
        .pc_ro(nb_pc_ro), .inst_ro(nb_inst_ro), .rs1data_ro(nb_rs1_ro), .rs2data_ro(nb_rs2_ro),
        .imm_ro(nb_imm_ro), .rd_ro(nb_rd_ro), .rdwe_ro(nb_rdwe_ro), .busy_o(nb_busy),
        .stall_cnt_o(nb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        fe.valid_i    = v;
        fe.pc_i       = pc;
        fe.inst_i     = inst;
        fe_nb.valid_i = v;
        fe_nb.pc_i    = pc;
        fe_nb.inst_i  = inst;
    endtask

    task automatic wb(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                      input logic [31:0] d0, input logic [31:0] d1);
        wb_valid = v;
        wb_rd    = {rd1, rd0};
        wb_data  = {d1, d0};
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        r0data  = 32'h5555;
        r1data  = 32'h6666;
        drive(1'b0, 32'h0, 32'h0);
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #11;
        chk("rst_valid", valid_ro, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_imm", imm_ro, 0);
        chk("rst_rdwe", rdwe_ro, 0);
        #1 rst_n = 1'b1;

        // addi x5,x0,7 then release via writeback
        drive(1'b1, 32'h100, 32'h00700293);
        #1 chk("addi_ready", fe.ready_o, 1);
        tick();
        chk("addi_valid", valid_ro, 1);
        chk("addi_imm", imm_ro, 7);
        chk("addi_rd", rd_ro, 5);
        chk("addi_rdwe", rdwe_ro, 1);
        chk("addi_rs1_x0", rs1_ro, 0);
        chk("addi_pc", pc_ro, 32'h100);
        chk("addi_busy", busy, 32'h20);
        drive(1'b0, 32'h0, 32'h0);
        wb(2'b01, 5'd5, 5'd0, 32'h77, 32'h0);
        tick();
        chk("wb5_busy", busy, 0);
        chk("wb5_valid_drop", valid_ro, 0);
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        // RAW stall on x5, then resolve with writeback
        drive(1'b1, 32'h104, 32'h00700293);
        tick();
        chk("resv5_busy", busy, 32'h20);
        chk("resv5_nb_busy", nb_busy, 32'h20);
        drive(1'b1, 32'h108, 32'h00528333);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw_ready", fe.ready_o, 0);
            chk("raw_nb_ready", fe_nb.ready_o, 0);
            tick();
        end
        chk("raw_stall", stall, 3);
        chk("raw_nb_stall", nb_stall, 3);
        chk("raw_valid", valid_ro, 0);
        wb(2'b01, 5'd5, 5'd0, 32'h1234, 32'h0);
        #1;
        chk("byp_ready", fe.ready_o, 1);
        chk("nobyp_ready", fe_nb.ready_o, 0);
        tick();
        chk("byp_valid", valid_ro, 1);
        chk("byp_rs1", rs1_ro, 32'h1234);
        chk("byp_rs2", rs2_ro, 32'h1234);
        chk("byp_busy", busy, 32'h40);
        chk("byp_stall", stall, 3);
        chk("nobyp_valid", nb_valid_ro, 0);
        chk("nobyp_stall", nb_stall, 4);
        chk("nobyp_busy", nb_busy, 0);
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        chk("nobyp_valid2", nb_valid_ro, 1);
        chk("nobyp_rs1", nb_rs1_ro, 32'h5555);
        chk("nobyp_rs2", nb_rs2_ro, 32'h6666);
        chk("nobyp_busy2", nb_busy, 32'h40);
        chk("rf_rs1_no_cov", rs1_ro, 32'h5555);
        drive(1'b0, 32'h0, 32'h0);
        wb(2'b01, 5'd6, 5'd0, 32'h0, 32'h0);
        tick();
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("clr6_busy", busy, 0);

        // Dual writeback to x7 in the issue cycle of lw x7,0(x7)
        drive(1'b1, 32'h10C, 32'h00100393);
        tick();
        chk("resv7_busy", busy, 32'h80);
        drive(1'b1, 32'h110, 32'h0003A383);
        wb(2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
        #1;
        chk("lw_ready", fe.ready_o, 1);
        chk("lw_r0num", r0num, 7);
        tick();
        chk("lw_rs1_low_port", rs1_ro, 32'hA);
        chk("lw_busy_set_wins", busy, 32'h80);
        chk("lw_rd", rd_ro, 7);
        chk("lw_imm", imm_ro, 0);
        drive(1'b0, 32'h0, 32'h0);
        wb(2'b01, 5'd7, 5'd0, 32'h0, 32'h0);
        tick();
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("clr7_busy", busy, 0);

        // Immediate formats
        drive(1'b1, 32'h200, 32'hFE21AE23);
        #1 chk("sw_r1num", r1num, 2);
        tick();
        chk("sw_imm", imm_ro, 32'hFFFFFFFC);
        chk("sw_rdwe", rdwe_ro, 0);
        chk("sw_busy", busy, 0);
        chk("sw_rs1", rs1_ro, 32'h5555);
        chk("sw_rs2", rs2_ro, 32'h6666);
        drive(1'b1, 32'h204, 32'h800000E3);
        tick();
        chk("beq_imm", imm_ro, 32'hFFFFF800);
        chk("beq_rdwe", rdwe_ro, 0);
        drive(1'b1, 32'h208, 32'h7FFFF06F);
        tick();
        chk("jal_pos_imm", imm_ro, 32'h000FFFFE);
        chk("jal_x0_rdwe", rdwe_ro, 0);
        drive(1'b1, 32'h20C, 32'h800000EF);
        tick();
        chk("jal_neg_imm", imm_ro, 32'hFFF00000);
        chk("jal_rdwe", rdwe_ro, 1);
        chk("jal_busy", busy, 32'h2);
        drive(1'b1, 32'h210, 32'h80000037);
        tick();
        chk("lui_imm", imm_ro, 32'h80000000);
        drive(1'b1, 32'h214, 32'hFFFFFFFF);
        tick();
        chk("unk_imm", imm_ro, 0);
        chk("unk_rdwe", rdwe_ro, 0);
        chk("unk_busy", busy, 32'h2);

        // Flush of a held rd-writing instruction
        drive(1'b1, 32'h300, 32'h00100493);
        tick();
        chk("x9_busy", busy, 32'h202);
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("hold_valid", valid_ro, 1);
        chk("hold_pc", pc_ro, 32'h300);
        flush_i = 1'b1;
        drive(1'b1, 32'h304, 32'h00100593);
        #1 chk("flush_ready", fe.ready_o, 0);
        tick();
        chk("flush_valid", valid_ro, 0);
        chk("flush_busy", busy, 32'h2);
        ready_i = 1'b1;
        #1 chk("flush_ready_cke", fe.ready_o, 0);
        tick();
        chk("flush2_valid", valid_ro, 0);
        chk("flush2_busy", busy, 32'h2);
        flush_i = 1'b0;

        // Asynchronous reset while stalled on x1
        drive(1'b1, 32'h400, 32'h00108333);
        #1 chk("x1_ready", fe.ready_o, 0);
        tick();
        chk("x1_stall", stall, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_stall", stall, 0);
        chk("arst_imm", imm_ro, 0);
        chk("arst_pc", pc_ro, 0);
        #2 rst_n = 1'b1;
        #1 chk("post_rst_ready", fe.ready_o, 1);
        @(posedge clk);
        #1;
        chk("post_rst_valid", valid_ro, 1);
        chk("post_rst_rd", rd_ro, 6);
        chk("post_rst_pc", pc_ro, 32'h400);
        chk("post_rst_busy", busy, 32'h40);
        drive(1'b1, 32'h404, 32'h00500013);
        wb(2'b01, 5'd0, 5'd0, 32'h99, 32'h0);
        tick();
        chk("x0_imm", imm_ro, 5);
        chk("x0_rdwe", rdwe_ro, 0);
        chk("x0_busy", busy, 32'h40);
        drive(1'b0, 32'h0, 32'h0);
        wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
